// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - ILI9341 power-up, init/loop command and pixel phase sequencer
// One shared down-counter times the reset/sleep delays and doubles as the busy watchdog.
module lcd_sequencer #(
  parameter int T_RST_LOW     = 10,
  parameter int T_RST_WAIT    = 120,
  parameter int T_SLPOUT_WAIT = 120,
  parameter int T_TIMEOUT     = 4096,
  parameter int MAX_RETRY     = 3,
  parameter int FCW           = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_restart,
  input  logic           i_comm_array_sent,
  input  logic           i_frame_done,
  output logic           o_lcd_rst_n,
  output logic           o_send_comm_ena,
  output logic           o_command,
  output logic           o_pixel_ena,
  output logic           o_init_done,
  output logic           o_error,
  output logic [FCW-1:0] o_frame_cnt
);

  localparam logic INI_COMM  = 1'b0;
  localparam logic LOOP_COMM = 1'b1;

  localparam int MAX_A   = (T_RST_LOW > T_RST_WAIT) ? T_RST_LOW : T_RST_WAIT;
  localparam int MAX_B   = (T_SLPOUT_WAIT > T_TIMEOUT) ? T_SLPOUT_WAIT : T_TIMEOUT;
  localparam int DLY_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int DW      = $clog2(DLY_MAX) + 1;
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DW-1:0] LD_RST_LOW  = DW'(T_RST_LOW - 1);
  localparam logic [DW-1:0] LD_RST_WAIT = DW'(T_RST_WAIT - 1);
  localparam logic [DW-1:0] LD_SLP_WAIT = DW'(T_SLPOUT_WAIT - 1);
  localparam logic [DW-1:0] LD_TIMEOUT  = DW'(T_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LIM   = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_RST_LOW, S_RST_WAIT, S_INIT_REQ, S_INIT_BUSY, S_SLP_WAIT,
    S_LOOP_REQ, S_LOOP_BUSY, S_PIXELS, S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  dly_q, dly_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           lcd_rst_n_q, lcd_rst_n_d;
  logic           send_ena_q, send_ena_d;
  logic           command_q, command_d;
  logic           pixel_ena_q, pixel_ena_d;
  logic           init_done_q, init_done_d;
  logic           error_q, error_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           watchdog;

  always_comb begin
    state_d     = state_q;
    dly_d       = (dly_q != '0) ? dly_q - 1'b1 : dly_q;
    retry_d     = retry_q;
    init_done_d = init_done_q;
    error_d     = error_q;
    frame_cnt_d = frame_cnt_q;
    watchdog    = 1'b0;

    case (state_q)
      S_RST_LOW: if (dly_q == '0) begin
        state_d = S_RST_WAIT;
        dly_d   = LD_RST_WAIT;
      end
      S_RST_WAIT: if (dly_q == '0) state_d = S_INIT_REQ;
      S_INIT_REQ: begin
        state_d = S_INIT_BUSY;
        dly_d   = LD_TIMEOUT;
      end
      S_INIT_BUSY: begin
        if (i_comm_array_sent) begin
          state_d = S_SLP_WAIT;
          dly_d   = LD_SLP_WAIT;
        end else if (dly_q == '0) begin
          watchdog = 1'b1;
        end
      end
      S_SLP_WAIT: if (dly_q == '0) begin
        state_d     = S_LOOP_REQ;
        init_done_d = 1'b1;
        retry_d     = '0;
      end
      S_LOOP_REQ: begin
        state_d = S_LOOP_BUSY;
        dly_d   = LD_TIMEOUT;
      end
      S_LOOP_BUSY: begin
        if (i_comm_array_sent) state_d = S_PIXELS;
        else if (dly_q == '0)  watchdog = 1'b1;
      end
      S_PIXELS: if (i_frame_done) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
        state_d     = S_LOOP_REQ;
      end
      S_ERROR: state_d = S_ERROR;
      default: begin
        state_d = S_RST_LOW;
        dly_d   = LD_RST_LOW;
      end
    endcase

    if (watchdog) begin
      if (retry_q < RETRY_LIM) begin
        retry_d = retry_q + 1'b1;
        state_d = S_RST_LOW;
        dly_d   = LD_RST_LOW;
      end else begin
        error_d = 1'b1;
        state_d = S_ERROR;
      end
    end

    // Restart overrides every other transition decided above.
    if (i_restart) begin
      state_d = S_RST_LOW;
      dly_d   = LD_RST_LOW;
      error_d = 1'b0;
      retry_d = '0;
    end

    if (state_d == S_RST_LOW) begin
      init_done_d = 1'b0;
      frame_cnt_d = '0;
    end

    // Outputs are decoded from the next state so they line up with state entry.
    lcd_rst_n_d = (state_d != S_RST_LOW);
    send_ena_d  = (state_d == S_INIT_REQ) || (state_d == S_LOOP_REQ);
    pixel_ena_d = (state_d == S_PIXELS);
    command_d   = command_q;
    if ((state_d == S_INIT_REQ) || (state_d == S_INIT_BUSY)) command_d = INI_COMM;
    if ((state_d == S_LOOP_REQ) || (state_d == S_LOOP_BUSY)) command_d = LOOP_COMM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RST_LOW;
      dly_q       <= LD_RST_LOW;
      retry_q     <= '0;
      lcd_rst_n_q <= 1'b0;
      send_ena_q  <= 1'b0;
      command_q   <= INI_COMM;
      pixel_ena_q <= 1'b0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      retry_q     <= retry_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      send_ena_q  <= send_ena_d;
      command_q   <= command_d;
      pixel_ena_q <= pixel_ena_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_lcd_rst_n     = lcd_rst_n_q;
  assign o_send_comm_ena = send_ena_q;
  assign o_command       = command_q;
  assign o_pixel_ena     = pixel_ena_q;
  assign o_init_done     = init_done_q;
  assign o_error         = error_q;
  assign o_frame_cnt     = frame_cnt_q;

endmodule
